sid_bus_arbiter: RTL and testbench
==================================

Name: sid_bus_arbiter

Overview:
Shares the SID register bus into sid_api between two requesters: the external 65xx pad bus (after sid_io) and a host write stream (USB/CDC command decoder).
- Each phi2 high phase is one access slot.
- A pad chip access always wins the slot.
- Idle slots drain a small host write FIFO, so host register writes land between CPU accesses without disturbing them.

Parameters:
FIFO_DEPTH, 4, host write FIFO entries; power of two, minimum 2.
SETTLE, 6, clk cycles after phi2 rise before pad chip select is sampled (250 ns at 24 MHz).

Ports:
clk  input  1  24 MHz system clock
rst_n  input  1  asynchronous active-low reset
phi2  input  1  synchronized SID master clock level
pad_cs_n  input  1  pad chip select, active low
pad_chip  input  2  pad chip index (decoded cs_n/cs_io1_n/a8/a5)
pad_we  input  1  pad write enable (from r_w_n)
pad_addr  input  5  pad register address
pad_data  input  8  pad write data
host_valid  input  1  host write request
host_ready  output  1  FIFO can accept
host_chip  input  2  host target chip
host_addr  input  5  host register address
host_data  input  8  host write data
sid_cs_n  output  1  granted chip select to sid_api, active low
sid_chip  output  2  granted chip index
sid_we  output  1  granted write enable
sid_addr  output  5  granted address
sid_data  output  8  granted write data
sid_src  output  1  0 = pad, 1 = host
fifo_level  output  3  FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
Reset (async assert, sync release):
- sid_cs_n=1; sid_chip, sid_we, sid_addr, sid_data, sid_src = 0.
- FIFO empty; fifo_level=0; host_ready=1 from the first cycle after release.

Edge detection:
- phi2_q is a registered phi2.
- rise = phi2 & ~phi2_q; fall = ~phi2 & phi2_q.

FSM:
- IDLE: on rise, go to SETTLE with cnt=0.
- SETTLE: cnt increments each cycle. When cnt==SETTLE-1, evaluate the slot:
  - pad_cs_n==0: go to PAD. Next cycle sid_* = pad inputs, sid_src=0, sid_cs_n=0. While in PAD, sid_we/addr/data track pad inputs every cycle.
  - else fifo_level!=0: pop the head, go to HOST. Next cycle sid_* = head entry, sid_we=1, sid_cs_n=0, sid_src=1. Values are held constant for the whole slot.
  - else: go to SKIP, no access issued.
- PAD / HOST / SKIP: on fall, go to IDLE. sid_cs_n=1 in the cycle after fall.
- fall seen while still in SETTLE (short phi2 high): abort to IDLE, no grant, no pop.
- At most one grant and one pop per phi2 period.

FIFO:
- Push when host_valid & host_ready; host_ready = (fifo_level != FIFO_DEPTH).
- Grant decision uses the registered fifo_level, so an entry pushed in the decision cycle is not eligible until the next slot.
- Simultaneous push and pop: level unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH.

Other rules:
- Pad reads (pad_we=0) are granted like writes; sid_api supplies data_o.
- Host entries are write-only.
- phi2 stopped: host entries wait indefinitely; no timeout.
- All outputs are registered; pad-to-sid latency is 1 clk once in PAD.

Optional Feature:
SID_ARB_STATS_EN
- When defined, adds outputs pad_grants [15:0], host_grants [15:0], host_stalls [15:0].
- pad_grants and host_grants count PAD and HOST slots respectively.
- host_stalls counts clk cycles with host_valid & ~host_ready.
- All counters saturate at 16'hFFFF and are zeroed by reset.
- When undefined, these ports and counters do not exist and the behaviour above is unchanged.

Decomposition:
- Package sid gains:
  - typedef arb_req_t: struct packed {chip[1:0], addr[4:0], data[7:0]}.
  - enum arb_state_t {IDLE, SETTLE, PAD, HOST, SKIP}.
  - constant ARB_FIFO_DEPTH=4.
- One sub-module, sid_arb_fifo: synchronous FIFO of arb_req_t with push/pop/level and async active-low reset.

Test Plan:
- Reset, then 3 host pushes {chip0,addr 5'h18,data 8'h0F}, {0,5'h00,8'h11}, {1,5'h04,8'h21} with pad_cs_n=1 → three consecutive phi2 slots issue them in order with sid_src=1, sid_we=1; fifo_level steps 3,2,1,0.
- Host entry queued; pad_cs_n=0, pad_we=1, addr 5'h12, data 8'h41 in the same slot → PAD granted with sid_addr=5'h12; host entry issued in the next idle slot; fifo_level stays 1 across the pad slot.
- Push FIFO_DEPTH=4 entries with phi2 held low → host_ready=0 and fifo_level=4; a 5th valid is not accepted; the first slot pops one entry and host_ready returns to 1.
- phi2 high pulse of 4 clk (< SETTLE) with FIFO non-empty → no grant, sid_cs_n stays 1, fifo_level unchanged.
- rst_n asserted mid-HOST slot → sid_cs_n=1 immediately and fifo_level=0; after release, first slot is SKIP.
- With SID_ARB_STATS_EN: 2 pad slots, 1 host slot, 10-cycle host stall → pad_grants=2, host_grants=1, host_stalls=10.

Source files
------------

// File: rtl/sid_bus_arbiter_pkg.sv
// Shared types and constants for the SID register bus arbiter.
package sid_bus_arbiter_pkg;

    localparam int ARB_FIFO_DEPTH = 4;

    // One host register write waiting for an idle slot.
    typedef struct packed {
        logic [1:0] chip;
        logic [4:0] addr;
        logic [7:0] data;
    } arb_req_t;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_SETTLE = 3'd1,
        ARB_PAD    = 3'd2,
        ARB_HOST   = 3'd3,
        ARB_SKIP   = 3'd4
    } arb_state_t;

    // Saturating 16-bit increment for event counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sid_arb_fifo.sv
// Host write FIFO: holds arb_req_t entries until an idle phi2 slot drains them.
// Push is ignored when full, pop is ignored when empty. The ready flag is
// registered so the host sees a clean flop output.
module sid_arb_fifo
    import sid_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = ARB_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  arb_req_t                 din_i,
    output arb_req_t                 dout_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ready_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    arb_req_t          mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ready_q, ready_d;
    logic              push_s, pop_s;

    assign push_s  = push_i & ready_q;
    assign pop_s   = pop_i & (level_q != {LW{1'b0}});
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign ready_o = ready_q;

    // Next pointer/level/ready; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
        ready_d = (level_d != LW'(DEPTH));
    end

    // Pointer, level and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/sid_bus_arbiter.sv
// SID register bus arbiter: each phi2 high phase is one access slot. A pad
// chip access always wins; otherwise the slot drains one queued host write.
// Optional build macro SID_ARB_STATS_EN adds saturating grant/stall counters.
module sid_bus_arbiter
    import sid_bus_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = ARB_FIFO_DEPTH,
    parameter int SETTLE     = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         phi2,
    input  logic                         pad_cs_n,
    input  logic [1:0]                   pad_chip,
    input  logic                         pad_we,
    input  logic [4:0]                   pad_addr,
    input  logic [7:0]                   pad_data,
    input  logic                         host_valid,
    output logic                         host_ready,
    input  logic [1:0]                   host_chip,
    input  logic [4:0]                   host_addr,
    input  logic [7:0]                   host_data,
    output logic                         sid_cs_n,
    output logic [1:0]                   sid_chip,
    output logic                         sid_we,
    output logic [4:0]                   sid_addr,
    output logic [7:0]                   sid_data,
    output logic                         sid_src,
`ifdef SID_ARB_STATS_EN
    output logic [15:0]                  pad_grants,
    output logic [15:0]                  host_grants,
    output logic [15:0]                  host_stalls,
`endif
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int CW = $clog2(SETTLE) + 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    arb_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           phi2_q;
    logic           rise_s, fall_s;

    logic           cs_n_q, cs_n_d;
    logic [1:0]     chip_q, chip_d;
    logic           we_q, we_d;
    logic [4:0]     addr_q, addr_d;
    logic [7:0]     data_q, data_d;
    logic           src_q, src_d;

    logic           push_s, pop_s;
    arb_req_t       push_req_s, head_s;
    logic [LW-1:0]  level_s;
    logic           ready_s;

    assign rise_s = phi2 & ~phi2_q;
    assign fall_s = ~phi2 & phi2_q;

    assign push_req_s = '{chip: host_chip, addr: host_addr, data: host_data};
    assign push_s     = host_valid & ready_s;

    sid_arb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (push_req_s),
        .dout_o  (head_s),
        .level_o (level_s),
        .ready_o (ready_s)
    );

    // Slot FSM: wait for chip select to settle, then grant pad, host or nothing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop_s   = 1'b0;
        cs_n_d  = cs_n_q;
        chip_d  = chip_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        src_d   = src_q;
        case (state_q)
            ARB_IDLE: begin
                if (rise_s) begin
                    state_d = ARB_SETTLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_SETTLE: begin
                if (fall_s) begin
                    // Short phi2 high: abandon the slot without granting.
                    state_d = ARB_IDLE;
                end else if (cnt_q == CW'(SETTLE - 1)) begin
                    if (!pad_cs_n) begin
                        state_d = ARB_PAD;
                        cs_n_d  = 1'b0;
                        chip_d  = pad_chip;
                        we_d    = pad_we;
                        addr_d  = pad_addr;
                        data_d  = pad_data;
                        src_d   = 1'b0;
                    end else if (level_s != {LW{1'b0}}) begin
                        state_d = ARB_HOST;
                        pop_s   = 1'b1;
                        cs_n_d  = 1'b0;
                        chip_d  = head_s.chip;
                        we_d    = 1'b1;
                        addr_d  = head_s.addr;
                        data_d  = head_s.data;
                        src_d   = 1'b1;
                    end else begin
                        state_d = ARB_SKIP;
                    end
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ARB_PAD: begin
                if (fall_s) begin
                    state_d = ARB_IDLE;
                    cs_n_d  = 1'b1;
                end else begin
                    // The CPU may still be driving the cycle; follow it.
                    we_d   = pad_we;
                    addr_d = pad_addr;
                    data_d = pad_data;
                end
            end
            ARB_HOST, ARB_SKIP: begin
                if (fall_s) begin
                    state_d = ARB_IDLE;
                    cs_n_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    // FSM state, settle counter and phi2 history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            cnt_q   <= {CW{1'b0}};
            phi2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi2_q  <= phi2;
        end
    end

    // Registered granted-access outputs toward sid_api.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_q <= 1'b1;
            chip_q <= 2'd0;
            we_q   <= 1'b0;
            addr_q <= 5'd0;
            data_q <= 8'd0;
            src_q  <= 1'b0;
        end else begin
            cs_n_q <= cs_n_d;
            chip_q <= chip_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            src_q  <= src_d;
        end
    end

    assign sid_cs_n   = cs_n_q;
    assign sid_chip   = chip_q;
    assign sid_we     = we_q;
    assign sid_addr   = addr_q;
    assign sid_data   = data_q;
    assign sid_src    = src_q;
    assign host_ready = ready_s;
    assign fifo_level = level_s;

`ifdef SID_ARB_STATS_EN
    logic [15:0] pad_grants_q, host_grants_q, host_stalls_q;

    // Saturating counters of pad slots, host slots and host stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_grants_q  <= 16'd0;
            host_grants_q <= 16'd0;
            host_stalls_q <= 16'd0;
        end else begin
            if (state_q == ARB_SETTLE && state_d == ARB_PAD) begin
                pad_grants_q <= sat_inc16(pad_grants_q);
            end
            if (state_q == ARB_SETTLE && state_d == ARB_HOST) begin
                host_grants_q <= sat_inc16(host_grants_q);
            end
            if (host_valid && !ready_s) begin
                host_stalls_q <= sat_inc16(host_stalls_q);
            end
        end
    end

    assign pad_grants  = pad_grants_q;
    assign host_grants = host_grants_q;
    assign host_stalls = host_stalls_q;
`endif

endmodule

// File: tb/tb_sid_bus_arbiter.sv
// Directed bench for sid_bus_arbiter: host draining, pad priority, FIFO full,
// short phi2 pulse, mid-slot reset and (with SID_ARB_STATS_EN) the counters.
module tb_sid_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       phi2;
    logic       pad_cs_n;
    logic [1:0] pad_chip;
    logic       pad_we;
    logic [4:0] pad_addr;
    logic [7:0] pad_data;
    logic       host_valid;
    logic       host_ready;
    logic [1:0] host_chip;
    logic [4:0] host_addr;
    logic [7:0] host_data;
    logic       sid_cs_n;
    logic [1:0] sid_chip;
    logic       sid_we;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic       sid_src;
    logic [2:0] fifo_level;
`ifdef SID_ARB_STATS_EN
    logic [15:0] pad_grants, host_grants, host_stalls;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sid_bus_arbiter #(
        .FIFO_DEPTH (4),
        .SETTLE     (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .phi2       (phi2),
        .pad_cs_n   (pad_cs_n),
        .pad_chip   (pad_chip),
        .pad_we     (pad_we),
        .pad_addr   (pad_addr),
        .pad_data   (pad_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_chip  (host_chip),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .sid_cs_n   (sid_cs_n),
        .sid_chip   (sid_chip),
        .sid_we     (sid_we),
        .sid_addr   (sid_addr),
        .sid_data   (sid_data),
        .sid_src    (sid_src),
`ifdef SID_ARB_STATS_EN
        .pad_grants (pad_grants),
        .host_grants(host_grants),
        .host_stalls(host_stalls),
`endif
        .fifo_level (fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic [4:0] a, input logic [7:0] d);
        host_valid = 1'b1;
        host_chip  = c;
        host_addr  = a;
        host_data  = d;
        tick(1);
        host_valid = 1'b0;
    endtask

    // Raise phi2 and wait until the grant decision has been registered.
    task automatic slot_open();
        phi2 = 1'b1;
        tick(7);
    endtask

    // Stay high a little, then drop phi2 and confirm the select is released.
    task automatic slot_close(input logic exp_cs_mid);
        tick(2);
        check("cs_n_mid_slot", 32'(sid_cs_n), 32'(exp_cs_mid));
        phi2 = 1'b0;
        tick(1);
        check("cs_n_after_fall", 32'(sid_cs_n), 32'd1);
        tick(3);
    endtask

    task automatic check_grant(input string tag, input logic src, input logic [1:0] c,
                               input logic we, input logic [4:0] a, input logic [7:0] d,
                               input logic [2:0] lvl);
        check({tag, "_cs_n"},  32'(sid_cs_n),   32'd0);
        check({tag, "_src"},   32'(sid_src),    32'(src));
        check({tag, "_chip"},  32'(sid_chip),   32'(c));
        check({tag, "_we"},    32'(sid_we),     32'(we));
        check({tag, "_addr"},  32'(sid_addr),   32'(a));
        check({tag, "_data"},  32'(sid_data),   32'(d));
        check({tag, "_level"}, 32'(fifo_level), 32'(lvl));
    endtask

    initial begin
        rst_n = 1'b0; phi2 = 1'b0;
        pad_cs_n = 1'b1; pad_chip = 2'd0; pad_we = 1'b0; pad_addr = 5'd0; pad_data = 8'd0;
        host_valid = 1'b0; host_chip = 2'd0; host_addr = 5'd0; host_data = 8'd0;

        // Reset state
        tick(2);
        check("rst_cs_n",  32'(sid_cs_n),   32'd1);
        check("rst_addr",  32'(sid_addr),   32'd0);
        check("rst_data",  32'(sid_data),   32'd0);
        check("rst_src",   32'(sid_src),    32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("rst_ready", 32'(host_ready), 32'd1);

        // Three host writes drained in order over three slots
        push(2'd0, 5'h18, 8'h0F);
        push(2'd0, 5'h00, 8'h11);
        push(2'd1, 5'h04, 8'h21);
        check("h3_level", 32'(fifo_level), 32'd3);
        slot_open();
        check_grant("h3_s1", 1'b1, 2'd0, 1'b1, 5'h18, 8'h0F, 3'd2);
        slot_close(1'b0);
        slot_open();
        check_grant("h3_s2", 1'b1, 2'd0, 1'b1, 5'h00, 8'h11, 3'd1);
        slot_close(1'b0);
        slot_open();
        check_grant("h3_s3", 1'b1, 2'd1, 1'b1, 5'h04, 8'h21, 3'd0);
        tick(1);
        check("h3_hold_addr", 32'(sid_addr), 32'h04);
        slot_close(1'b0);

        // Pad wins the slot while a host entry waits
        push(2'd2, 5'h0A, 8'h55);
        pad_cs_n = 1'b0; pad_we = 1'b1; pad_chip = 2'd3; pad_addr = 5'h12; pad_data = 8'h41;
        slot_open();
        check_grant("pad", 1'b0, 2'd3, 1'b1, 5'h12, 8'h41, 3'd1);
        pad_data = 8'h42; pad_we = 1'b0;
        tick(1);
        check("pad_track_data", 32'(sid_data), 32'h42);
        check("pad_track_we",   32'(sid_we),   32'd0);
        slot_close(1'b0);
        pad_cs_n = 1'b1;
        check("pad_level_after", 32'(fifo_level), 32'd1);
        slot_open();
        check_grant("pad_next_host", 1'b1, 2'd2, 1'b1, 5'h0A, 8'h55, 3'd0);
        slot_close(1'b0);

        // Fill the FIFO with phi2 low; fifth push is refused
        push(2'd0, 5'h01, 8'hA1);
        push(2'd0, 5'h02, 8'hA2);
        push(2'd0, 5'h03, 8'hA3);
        push(2'd0, 5'h04, 8'hA4);
        check("full_level", 32'(fifo_level), 32'd4);
        check("full_ready", 32'(host_ready), 32'd0);
        push(2'd0, 5'h05, 8'hA5);
        check("full_level_5th", 32'(fifo_level), 32'd4);
        slot_open();
        check_grant("full_pop", 1'b1, 2'd0, 1'b1, 5'h01, 8'hA1, 3'd3);
        check("full_ready_back", 32'(host_ready), 32'd1);
        slot_close(1'b0);

        // Short phi2 pulse: no grant, no pop
        phi2 = 1'b1;
        tick(4);
        check("short_cs_n_high", 32'(sid_cs_n), 32'd1);
        phi2 = 1'b0;
        tick(4);
        check("short_cs_n_after", 32'(sid_cs_n),   32'd1);
        check("short_level",      32'(fifo_level), 32'd3);
        slot_open();
        check_grant("short_next", 1'b1, 2'd0, 1'b1, 5'h02, 8'hA2, 3'd2);
        slot_close(1'b0);
        slot_open();
        check_grant("drain_a3", 1'b1, 2'd0, 1'b1, 5'h03, 8'hA3, 3'd1);
        slot_close(1'b0);
        slot_open();
        check_grant("drain_a4", 1'b1, 2'd0, 1'b1, 5'h04, 8'hA4, 3'd0);
        slot_close(1'b0);
        slot_open();
        check("empty_skip_cs_n", 32'(sid_cs_n), 32'd1);
        slot_close(1'b1);

        // Reset in the middle of a host slot
        push(2'd1, 5'h1F, 8'h77);
        push(2'd1, 5'h1E, 8'h66);
        slot_open();
        check_grant("mid_host", 1'b1, 2'd1, 1'b1, 5'h1F, 8'h77, 3'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n",  32'(sid_cs_n),   32'd1);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_src",   32'(sid_src),    32'd0);
        phi2 = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        slot_open();
        check("post_rst_skip_cs_n", 32'(sid_cs_n),   32'd1);
        check("post_rst_level",     32'(fifo_level), 32'd0);
        slot_close(1'b1);

`ifdef SID_ARB_STATS_EN
        // Counters: two pad slots, one host slot, ten stall cycles
        pad_cs_n = 1'b0;
        slot_open();
        slot_close(1'b0);
        slot_open();
        slot_close(1'b0);
        pad_cs_n = 1'b1;
        push(2'd0, 5'h07, 8'h99);
        slot_open();
        slot_close(1'b0);
        host_valid = 1'b1;
        tick(14);
        host_valid = 1'b0;
        check("stat_pad_grants",  32'(pad_grants),  32'd2);
        check("stat_host_grants", 32'(host_grants), 32'd1);
        check("stat_host_stalls", 32'(host_stalls), 32'd10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
